// File: rtl/btn_event_pkg.sv
// Shared types and default timing constants for the button event classifier.
// The optional double-click path is enabled by defining BTN_DOUBLE_CLICK_EN.
package btn_event_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESSED   = 3'd1,
        LONG_HELD = 3'd2,
        WAIT_GAP  = 3'd3,
        SECOND    = 3'd4
    } btn_state_t;

    localparam int LONG_CYCLES_DEF    = 50_000_000;
    localparam int DBL_GAP_CYCLES_DEF = 12_500_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Registers the debounced level once and derives one-cycle rise/fall strobes.
// Edges are suppressed in the first cycle after reset so a held button is not seen as a press.
module btn_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic prev_q;
    logic prev_d;
    logic armed_q;
    logic armed_d;

    always_comb begin
        prev_d  = level;
        armed_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    assign rise = armed_q &  level & ~prev_q;
    assign fall = armed_q & ~level &  prev_q;

endmodule

// File: rtl/button_event_classifier.sv
// Classifies debounced button activity into short, long and double-click pulses.
// Double-click support (WAIT_GAP/SECOND states) is compiled in only when BTN_DOUBLE_CLICK_EN is defined.
module button_event_classifier
    import btn_event_pkg::*;
#(
    parameter int LONG_CYCLES    = LONG_CYCLES_DEF,
    parameter int DBL_GAP_CYCLES = DBL_GAP_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_clean,
    output logic       short_press,
    output logic       long_press,
    output logic       double_click,
    output logic [7:0] event_count
);

    localparam int MAX_CYC = max_int(LONG_CYCLES, DBL_GAP_CYCLES);
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BTN_DOUBLE_CLICK_EN
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_CYCLES - 1);
`endif

    logic rise;
    logic fall;

    btn_edge_detect u_edge (
        .clk   (clk),
        .rst   (rst),
        .level (btn_clean),
        .rise  (rise),
        .fall  (fall)
    );

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             dbl_d;
    logic [7:0]       event_count_q, event_count_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            short_q       <= 1'b0;
            long_q        <= 1'b0;
            event_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            short_q       <= short_d;
            long_q        <= long_d;
            event_count_q <= event_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end
            end
            PRESSED: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fall) begin
`ifdef BTN_DOUBLE_CLICK_EN
                    state_d = WAIT_GAP;
                    cnt_d   = '0;
`else
                    state_d = IDLE;
`endif
                end else if (btn_clean && cnt_q == LONG_LAST) begin
                    state_d = LONG_HELD;
                end
            end
            LONG_HELD: begin
                if (fall) begin
                    state_d = IDLE;
                end
            end
`ifdef BTN_DOUBLE_CLICK_EN
            WAIT_GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A rise in the timeout cycle still counts as the second click.
                if (rise) begin
                    state_d = SECOND;
                    cnt_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            SECOND: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (fall) begin
                    state_d = IDLE;
                end else if (btn_clean && cnt_q == LONG_LAST) begin
                    state_d = LONG_HELD;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
        case (state_q)
            PRESSED: begin
                if (fall) begin
`ifndef BTN_DOUBLE_CLICK_EN
                    short_d = 1'b1;
`endif
                end else if (btn_clean && cnt_q == LONG_LAST) begin
                    long_d = 1'b1;
                end
            end
`ifdef BTN_DOUBLE_CLICK_EN
            WAIT_GAP: begin
                if (!rise && cnt_q == GAP_LAST) begin
                    short_d = 1'b1;
                end
            end
            SECOND: begin
                if (fall) begin
                    dbl_d = 1'b1;
                end else if (btn_clean && cnt_q == LONG_LAST) begin
                    long_d = 1'b1;
                end
            end
`endif
            default: ;
        endcase
        event_count_d = event_count_q + {7'd0, (short_d | long_d | dbl_d)};
    end

`ifdef BTN_DOUBLE_CLICK_EN
    logic dbl_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dbl_q <= 1'b0;
        end else begin
            dbl_q <= dbl_d;
        end
    end

    assign double_click = dbl_q;
`else
    assign double_click = 1'b0;
`endif

    assign short_press = short_q;
    assign long_press  = long_q;
    assign event_count = event_count_q;

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed bench for button_event_classifier with LONG_CYCLES=20, DBL_GAP_CYCLES=8.
// Expectations adapt to whether BTN_DOUBLE_CLICK_EN is defined.
module tb_button_event_classifier;

    localparam int LONG = 20;
    localparam int GAP  = 8;
`ifdef BTN_DOUBLE_CLICK_EN
    localparam int DC = 1;
`else
    localparam int DC = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       btn;
    logic       short_press;
    logic       long_press;
    logic       double_click;
    logic [7:0] event_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    button_event_classifier #(
        .LONG_CYCLES    (LONG),
        .DBL_GAP_CYCLES (GAP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_clean    (btn),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .event_count  (event_count)
    );

    // Cycle index and pulse monitor; pulses are sampled mid-cycle on the falling edge.
    int cyc = 0;
    int n_short = 0, n_long = 0, n_dbl = 0, n_multi = 0;
    int t_short = -1, t_long = -1, t_dbl = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (short_press === 1'b1) begin
            n_short <= n_short + 1;
            t_short <= cyc;
        end
        if (long_press === 1'b1) begin
            n_long <= n_long + 1;
            t_long <= cyc;
        end
        if (double_click === 1'b1) begin
            n_dbl <= n_dbl + 1;
            t_dbl <= cyc;
        end
        if ((int'(short_press) + int'(long_press) + int'(double_click)) > 1)
            n_multi <= n_multi + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int n);
        btn = v;
        step(n);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        btn = 1'b0;
        step(3);
        checks++;
        if ({short_press, long_press, double_click} !== 3'b000) begin
            failures++;
            $display("FAIL reset_pulses got=%b want=000", {short_press, long_press, double_click});
        end
        checks++;
        if (event_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d want=0", event_count);
        end
        rst = 1'b0;
        step(2);
        $display("reset: pulses=%b count=%0d", {short_press, long_press, double_click}, event_count);
    endtask

    task automatic test_short;
        int s0, l0, d0, fe;
        s0 = n_short; l0 = n_long; d0 = n_dbl;
        drive(1'b1, 5);
        fe = cyc + 1;
        drive(1'b0, 14);
        checks++;
        if (n_short - s0 !== 1) begin
            failures++;
            $display("FAIL short_count got=%0d want=1", n_short - s0);
        end
        checks++;
        if (t_short !== fe + DC * GAP) begin
            failures++;
            $display("FAIL short_timing got=%0d want=%0d", t_short, fe + DC * GAP);
        end
        checks++;
        if ((n_long - l0) + (n_dbl - d0) !== 0) begin
            failures++;
            $display("FAIL short_other got=%0d want=0", (n_long - l0) + (n_dbl - d0));
        end
        checks++;
        if (event_count !== 8'd1) begin
            failures++;
            $display("FAIL short_evcount got=%0d want=1", event_count);
        end
        $display("short: fall=%0d pulse=%0d count=%0d", fe, t_short, event_count);
    endtask

    task automatic test_long;
        int s0, l0, d0, re;
        s0 = n_short; l0 = n_long; d0 = n_dbl;
        re = cyc + 1;
        drive(1'b1, 30);
        drive(1'b0, 14);
        checks++;
        if (n_long - l0 !== 1) begin
            failures++;
            $display("FAIL long_count got=%0d want=1", n_long - l0);
        end
        checks++;
        if (t_long !== re + LONG) begin
            failures++;
            $display("FAIL long_timing got=%0d want=%0d", t_long, re + LONG);
        end
        checks++;
        if ((n_short - s0) + (n_dbl - d0) !== 0) begin
            failures++;
            $display("FAIL long_release_pulse got=%0d want=0", (n_short - s0) + (n_dbl - d0));
        end
        checks++;
        if (event_count !== 8'd2) begin
            failures++;
            $display("FAIL long_evcount got=%0d want=2", event_count);
        end
        $display("long: rise=%0d pulse=%0d count=%0d", re, t_long, event_count);
    endtask

    task automatic test_double;
        int s0, d0, f2, td0;
        s0 = n_short; d0 = n_dbl; td0 = t_dbl;
        drive(1'b1, 3);
        drive(1'b0, 4);
        drive(1'b1, 3);
        f2 = cyc + 1;
        drive(1'b0, 14);
        checks++;
        if (n_dbl - d0 !== DC) begin
            failures++;
            $display("FAIL double_count got=%0d want=%0d", n_dbl - d0, DC);
        end
        checks++;
        if (n_short - s0 !== 2 - 2 * DC) begin
            failures++;
            $display("FAIL double_short got=%0d want=%0d", n_short - s0, 2 - 2 * DC);
        end
        checks++;
        if (t_dbl !== (DC == 1 ? f2 : td0)) begin
            failures++;
            $display("FAIL double_timing got=%0d want=%0d", t_dbl, (DC == 1 ? f2 : td0));
        end
        checks++;
        if (event_count !== 8'(4 - DC)) begin
            failures++;
            $display("FAIL double_evcount got=%0d want=%0d", event_count, 4 - DC);
        end
        $display("double: fall2=%0d dbl=%0d shorts=%0d", f2, n_dbl - d0, n_short - s0);
    endtask

    task automatic test_gap_boundary;
        int s0, d0, f0, f1;
        // Rise lands exactly in the timeout cycle.
        s0 = n_short; d0 = n_dbl;
        drive(1'b1, 3);
        drive(1'b0, 8);
        drive(1'b1, 3);
        drive(1'b0, 14);
        checks++;
        if (n_short - s0 !== 2 - 2 * DC) begin
            failures++;
            $display("FAIL gap_edge_short got=%0d want=%0d", n_short - s0, 2 - 2 * DC);
        end
        checks++;
        if (n_dbl - d0 !== DC) begin
            failures++;
            $display("FAIL gap_edge_double got=%0d want=%0d", n_dbl - d0, DC);
        end
        $display("gap_edge: shorts=%0d dbl=%0d", n_short - s0, n_dbl - d0);
        // Rise one cycle after timeout starts a fresh press.
        s0 = n_short; d0 = n_dbl;
        drive(1'b1, 3);
        f0 = cyc + 1;
        drive(1'b0, 9);
        drive(1'b1, 3);
        checks++;
        if (t_short !== f0 + DC * GAP) begin
            failures++;
            $display("FAIL gap_late_timing got=%0d want=%0d", t_short, f0 + DC * GAP);
        end
        f1 = cyc + 1;
        drive(1'b0, 14);
        checks++;
        if (n_short - s0 !== 2 || n_dbl - d0 !== 0) begin
            failures++;
            $display("FAIL gap_late_counts got=%0d/%0d want=2/0", n_short - s0, n_dbl - d0);
        end
        checks++;
        if (t_short !== f1 + DC * GAP) begin
            failures++;
            $display("FAIL gap_late_second got=%0d want=%0d", t_short, f1 + DC * GAP);
        end
        $display("gap_late: shorts=%0d last=%0d", n_short - s0, t_short);
    endtask

    task automatic test_second_long;
        int s0, l0, d0, r2;
        s0 = n_short; l0 = n_long; d0 = n_dbl;
        drive(1'b1, 3);
        drive(1'b0, 2);
        r2 = cyc + 1;
        drive(1'b1, 30);
        drive(1'b0, 14);
        checks++;
        if (n_long - l0 !== 1 || t_long !== r2 + LONG) begin
            failures++;
            $display("FAIL second_long got=%0d@%0d want=1@%0d", n_long - l0, t_long, r2 + LONG);
        end
        checks++;
        if (n_short - s0 !== 1 - DC || n_dbl - d0 !== 0) begin
            failures++;
            $display("FAIL second_long_other got=%0d/%0d want=%0d/0", n_short - s0, n_dbl - d0, 1 - DC);
        end
        $display("second_long: rise2=%0d long=%0d", r2, t_long);
    endtask

    task automatic test_reset_gap;
        int s0, l0, d0;
        s0 = n_short; l0 = n_long; d0 = n_dbl;
        drive(1'b1, 3);
        drive(1'b0, 3);
        rst = 1'b1;
        step(1);
        checks++;
        if ({short_press, long_press, double_click} !== 3'b000 || event_count !== 8'd0) begin
            failures++;
            $display("FAIL rst_gap_outputs got=%b/%0d want=000/0",
                     {short_press, long_press, double_click}, event_count);
        end
        rst = 1'b0;
        step(15);
        checks++;
        if (n_short - s0 !== 1 - DC || (n_long - l0) + (n_dbl - d0) !== 0) begin
            failures++;
            $display("FAIL rst_gap_pulses got=%0d want=%0d", n_short - s0, 1 - DC);
        end
        checks++;
        if (event_count !== 8'd0) begin
            failures++;
            $display("FAIL rst_gap_evcount got=%0d want=0", event_count);
        end
        $display("reset_gap: shorts=%0d count=%0d", n_short - s0, event_count);
    endtask

    task automatic test_held_reset;
        int s0, l0, d0;
        s0 = n_short; l0 = n_long; d0 = n_dbl;
        rst = 1'b1;
        btn = 1'b1;
        step(2);
        rst = 1'b0;
        drive(1'b1, 30);
        drive(1'b0, 14);
        checks++;
        if ((n_short - s0) + (n_long - l0) + (n_dbl - d0) !== 0 || event_count !== 8'd0) begin
            failures++;
            $display("FAIL held_reset got=%0d/%0d want=0/0",
                     (n_short - s0) + (n_long - l0) + (n_dbl - d0), event_count);
        end
        drive(1'b1, 5);
        drive(1'b0, 14);
        checks++;
        if (n_short - s0 !== 1 || event_count !== 8'd1) begin
            failures++;
            $display("FAIL held_reset_repress got=%0d/%0d want=1/1", n_short - s0, event_count);
        end
        $display("held_reset: shorts=%0d count=%0d", n_short - s0, event_count);
    endtask

    task automatic test_wrap;
        int s0;
        rst = 1'b1;
        btn = 1'b0;
        step(1);
        rst = 1'b0;
        step(2);
        s0 = n_short;
        for (int i = 0; i < 255; i++) begin
            drive(1'b1, 2);
            drive(1'b0, 2 + DC * 8);
        end
        checks++;
        if (event_count !== 8'd255) begin
            failures++;
            $display("FAIL wrap_255 got=%0d want=255", event_count);
        end
        drive(1'b1, 2);
        drive(1'b0, 2 + DC * 8);
        checks++;
        if (event_count !== 8'd0 || n_short - s0 !== 256) begin
            failures++;
            $display("FAIL wrap_0 got=%0d/%0d want=0/256", event_count, n_short - s0);
        end
        checks++;
        if (n_multi !== 0) begin
            failures++;
            $display("FAIL one_hot got=%0d want=0", n_multi);
        end
        $display("wrap: shorts=%0d count=%0d", n_short - s0, event_count);
    endtask

    initial begin
        test_reset();
        test_short();
        test_long();
        test_double();
        test_gap_boundary();
        test_second_long();
        test_reset_gap();
        test_held_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
